// File: rtl/line_window_3x3.sv
// 3x3 pixel window from a raster stream via two line buffers; 1-clk latency, no backpressure (upstream paces pixels).
// Define WIN_COORD_EN to add win_x_o/win_y_o window-center coordinate outputs.
module line_window_3x3 #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int DATA_W     = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pix_valid_i,
  input  logic                          sof_i,
  input  logic [DATA_W-1:0]             pix_data_i,
  output logic [DATA_W-1:0]             data_00_o,
  output logic [DATA_W-1:0]             data_01_o,
  output logic [DATA_W-1:0]             data_02_o,
  output logic [DATA_W-1:0]             data_10_o,
  output logic [DATA_W-1:0]             data_11_o,
  output logic [DATA_W-1:0]             data_12_o,
  output logic [DATA_W-1:0]             data_20_o,
  output logic [DATA_W-1:0]             data_21_o,
  output logic [DATA_W-1:0]             data_22_o,
`ifdef WIN_COORD_EN
  output logic [$clog2(IMG_WIDTH)-1:0]  win_x_o,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_y_o,
`endif
  output logic                          win_valid_o
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  logic [XW-1:0]     x_q, x_d, px;
  logic [YW-1:0]     y_q, y_d, py;
  logic [DATA_W-1:0] lb0_mem [IMG_WIDTH];
  logic [DATA_W-1:0] lb1_mem [IMG_WIDTH];
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] win_d [3][3];
  logic              win_valid_q, win_valid_d;
  logic              win_gate;

  // A qualified sof forces the current pixel to (0,0) regardless of the counters.
  always_comb begin
    px       = sof_i ? '0 : x_q;
    py       = sof_i ? '0 : y_q;
    win_gate = pix_valid_i && (px >= XW'(2)) && (py >= YW'(2));
    x_d         = x_q;
    y_d         = y_q;
    win_d       = win_q;
    win_valid_d = win_gate;
    if (pix_valid_i) begin
      if (px == XW'(IMG_WIDTH - 1)) begin
        x_d = '0;
        y_d = (py == YW'(IMG_HEIGHT - 1)) ? '0 : py + YW'(1);
      end else begin
        x_d = px + XW'(1);
        y_d = py;
      end
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 2; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      win_d[0][2] = lb1_mem[px];
      win_d[1][2] = lb0_mem[px];
      win_d[2][2] = pix_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      win_valid_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      win_valid_q <= win_valid_d;
      win_q       <= win_d;
    end
  end

  // Line buffers are never cleared; rows only reach the output once y>=2 of the current frame.
  always_ff @(posedge clk) begin
    if (pix_valid_i && !reset) begin
      lb1_mem[px] <= lb0_mem[px];
      lb0_mem[px] <= pix_data_i;
    end
  end

`ifdef WIN_COORD_EN
  logic [XW-1:0] win_x_q, win_x_d;
  logic [YW-1:0] win_y_q, win_y_d;

  always_comb begin
    win_x_d = win_x_q;
    win_y_d = win_y_q;
    if (win_gate) begin
      win_x_d = px - XW'(1);
      win_y_d = py - YW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_x_q <= '0;
      win_y_q <= '0;
    end else begin
      win_x_q <= win_x_d;
      win_y_q <= win_y_d;
    end
  end

  assign win_x_o = win_x_q;
  assign win_y_o = win_y_q;
`endif

  assign data_00_o   = win_q[0][0];
  assign data_01_o   = win_q[0][1];
  assign data_02_o   = win_q[0][2];
  assign data_10_o   = win_q[1][0];
  assign data_11_o   = win_q[1][1];
  assign data_12_o   = win_q[1][2];
  assign data_20_o   = win_q[2][0];
  assign data_21_o   = win_q[2][1];
  assign data_22_o   = win_q[2][2];
  assign win_valid_o = win_valid_q;

endmodule
